// File: rtl/msg_uart_tx.sv
// Message sequencer + 8N1 UART transmitter: walks the character ROM from
// address 0 and serializes each byte until a NUL or MSG_LEN characters.
//
// state | meaning
// IDLE  | line high, waiting for start
// LOAD  | sample rom_data; NUL ends the message
// START | start bit (tx=0) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (tx=1), then next address or finish
module msg_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MSG_LEN      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_ADDR = 4'(MSG_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            baud_end;

  assign baud_end = (baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= 4'd0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      baud     <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (start) begin
            rom_addr <= 4'd0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (rom_data == 8'h00) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            shift   <= rom_data;
            baud    <= '0;
            bit_cnt <= 3'd0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud  <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          // shift[0] always holds the bit currently on the line
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (rom_addr == LAST_ADDR) begin
              done     <= 1'b1;
              busy     <= 1'b0;
              rom_addr <= 4'd0;
              state    <= IDLE;
            end else begin
              rom_addr <= rom_addr + 4'd1;
              state    <= LOAD;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
